// File: rtl/x_rams_dp_clr.sv
// Dual-read-port distributed RAM with AND-ed write enables, optional registered
// outputs and a reset-launched sequencer that zeroes the array one word per cycle.
module x_rams_dp_clr #(
  parameter int                         WIDTH      = 8,
  parameter int                         ADDR_WIDTH = 6,
  parameter int                         DEPTH      = 2 ** ADDR_WIDTH,
  parameter logic [DEPTH*WIDTH-1:0]     INIT       = '0,
  parameter bit                         OUT_REG    = 1'b0,
  parameter string                      WRITE_MODE = "READ_FIRST",
  parameter bit                         CLR_ON_RST = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic                  WE1,
  input  logic                  WE2,
  input  logic [ADDR_WIDTH-1:0] ADR,
  input  logic [WIDTH-1:0]      I,
  input  logic [ADDR_WIDTH-1:0] DPRA,
  output logic [WIDTH-1:0]      SPO,
  output logic [WIDTH-1:0]      DPO,
  output logic                  BUSY
);

  localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];
  typedef enum logic {IDLE, CLEAR} state_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int k = 0; k < DEPTH; k++) begin
      m[k] = INIT[k*WIDTH +: WIDTH];
    end
    return m;
  endfunction

  mem_t                  mem     = init_mem();
  state_t                state_q = IDLE;
  logic [ADDR_WIDTH-1:0] cnt_q   = '0;

  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  clr_we;
  logic                  user_we;
  logic                  adr_ok;
  logic                  dpra_ok;
  logic [WIDTH-1:0]      rd_a;
  logic [WIDTH-1:0]      rd_b;

  assign adr_ok  = (32'(ADR) < DEPTH);
  assign dpra_ok = (32'(DPRA) < DEPTH);
  assign rd_a    = adr_ok  ? mem[ADR]  : '0;
  assign rd_b    = dpra_ok ? mem[DPRA] : '0;

  assign BUSY    = (state_q == CLEAR);
  assign user_we = WE & WE1 & WE2 & ~BUSY & ~RST & adr_ok;

  // Clear sequencer: RST always (re)starts from word 0; release walks the array.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (CLR_ON_RST) begin
      if (RST) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end else if (state_q == CLEAR) begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (user_we) begin
      mem[ADR] <= I;
    end
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [WIDTH-1:0] spo_p1 = '0;
      logic [WIDTH-1:0] dpo_p1 = '0;

      // Output register stage: collision bypass selects old or new word.
      always_ff @(posedge CLK) begin
        if (RST || BUSY) begin
          spo_p1 <= '0;
          dpo_p1 <= '0;
        end else begin
          spo_p1 <= (WRITE_FIRST && user_we) ? I : rd_a;
          dpo_p1 <= (WRITE_FIRST && user_we && (DPRA == ADR)) ? I : rd_b;
        end
      end

      assign SPO = spo_p1;
      assign DPO = dpo_p1;
    end else begin : g_comb
      assign SPO = rd_a;
      assign DPO = rd_b;
    end
  endgenerate

endmodule

// File: doc/x_rams_dp_clr.md
# x_rams_dp_clr

Parametrised dual-read-port distributed RAM: the multi-bit, variable-depth successor to the single-bit 64-deep LUT RAM simprim. One synchronous write port gated by three AND-ed write enables, two read ports, an optional registered output with selectable collision mode, and a reset-triggered clear sequencer that zeroes the array one word per cycle. Used wherever register files, small lookup tables or scratchpads need a known-zero state after reset without reloading INIT.

## Interface
Parameters:
- WIDTH, 8: data word width, 1..64.
- ADDR_WIDTH, 6: address width, 1..10.
- DEPTH, 2**ADDR_WIDTH: number of words, 1..2**ADDR_WIDTH.
- INIT, all zeros (DEPTH*WIDTH bits): power-up contents; word k = INIT[k*WIDTH +: WIDTH].
- OUT_REG, 0: 0 = combinational read outputs; 1 = registered read outputs.
- WRITE_MODE, "READ_FIRST": collision rule when OUT_REG=1; "READ_FIRST" or "WRITE_FIRST".
- CLR_ON_RST, 1: 1 = reset launches the clear sequence; 0 = reset leaves memory intact.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- WE, WE1, WE2  in  1 each  write enables; write occurs only when all three are 1.
- ADR  in  ADDR_WIDTH  write address and port-A read address.
- I  in  WIDTH  write data.
- DPRA  in  ADDR_WIDTH  port-B read address.
- SPO  out  WIDTH  port-A read data.
- DPO  out  WIDTH  port-B read data.
- BUSY  out  1  clear sequence in progress; user writes ignored.

## Operation
- Power-up: mem loaded from INIT; state IDLE, BUSY=0, clear counter 0, registered outputs 0.
- User write: on rising CLK with WE&WE1&WE2=1, BUSY=0, RST=0 and ADR<DEPTH, mem[ADR] <= I. Any X/0 on an enable blocks the write.
- Out-of-range address (>=DEPTH): writes dropped; reads return 0.
- OUT_REG=0: SPO=mem[ADR], DPO=mem[DPRA], combinational; follow memory changes in the same delta after the write edge. No reset value (reflect contents).
- OUT_REG=1: SPO/DPO registered each edge from mem[ADR]/mem[DPRA]. If a user write hits the same address in that edge: READ_FIRST yields old word, WRITE_FIRST yields I. Registered outputs forced 0 while RST=1 or BUSY=1.
- Clear FSM (CLR_ON_RST=1), states IDLE, CLEAR:
  - Any edge with RST=1: state <= CLEAR, counter <= 0, BUSY <= 1, no memory write (also aborts an in-progress clear and restarts it).
  - CLEAR with RST=0: mem[counter] <= 0, counter++; on the edge that writes word DEPTH-1, state <= IDLE, BUSY <= 0, counter <= 0.
- CLR_ON_RST=0: RST only zeroes registered outputs; BUSY stays 0; memory retained; user writes blocked only on edges with RST=1.

## Timing
- Write latency: 1 edge; combinational reads show new data after that edge, registered reads one edge later (READ_FIRST) or on the write edge (WRITE_FIRST).
- Clear: BUSY=1 from first edge with RST=1; deasserts exactly DEPTH edges after the first edge with RST=0. First user write accepted on the edge after BUSY falls.
- DEPTH=1: clear takes one edge.
- RST asserted mid-clear: counter returns to 0, words already cleared stay 0, full DEPTH-cycle sequence restarts after release.

## Test plan
- WIDTH=8, DEPTH=64, INIT word 5=8'hA5, OUT_REG=0: read ADR=5 at time 0 -> SPO=8'hA5; write 8'h3C to 5 with WE2=0 -> SPO stays 8'hA5; all enables 1 -> SPO=8'h3C after edge.
- Pulse RST 1 cycle, CLR_ON_RST=1, DEPTH=64: BUSY high 64 edges after release; writes attempted during BUSY dropped; afterwards every address reads 0.
- OUT_REG=1, READ_FIRST: mem[7]=8'h11, write 8'h22 to 7 with DPRA=7 -> SPO=DPO=8'h11 that edge, 8'h22 next edge; WRITE_FIRST -> 8'h22 immediately.
- DEPTH=48, ADDR_WIDTH=6: write to 50 -> ignored; DPRA=50 -> DPO=0; clear takes 48 edges.
- RST re-asserted at clear cycle 20 for 3 cycles -> BUSY stays 1, falls 64 edges after second release; CLR_ON_RST=0 variant: RST leaves mem[5]=8'hA5, BUSY never rises.
